// File: rtl/geofence_host.sv
// Geofence host: streams six-point objects from the pattern ROM to the geofence
// receiver, prefetching the next object while the receiver works, and logs results.
module geofence_host #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  num_obj,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        rom_rd,
   output logic [10:0] rom_addr,
   input  logic [30:0] rom_data,
   output logic        gf_reset,
   output logic [9:0]  X,
   output logic [9:0]  Y,
   output logic [10:0] R,
   input  logic        valid,
   input  logic        is_inside,
   output logic        res_we,
   output logic [7:0]  res_addr,
   output logic        res_data
);

   typedef enum logic [2:0] {IDLE, PREF, SEND, WAIT, FIN} state_t;

   localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT_CYC - 1);

   state_t      state_reg, state_next;
   logic        busy_reg, busy_next, done_reg, done_next, err_reg, err_next;
   logic        rom_rd_reg, rom_rd_next, rd_d_reg, pf_done_reg, pf_done_next;
   logic [10:0] rom_addr_reg, rom_addr_next, next_addr_reg, next_addr_next;
   logic [2:0]  rd_cnt_reg, rd_cnt_next, cap_cnt_reg, cap_cnt_next;
   logic [2:0]  send_cnt_reg, send_cnt_next;
   logic [9:0]  wait_cnt_reg, wait_cnt_next;
   logic [7:0]  obj_idx_reg, obj_idx_next, num_reg, num_next;
   logic        gf_reset_reg, gf_reset_next;
   logic [9:0]  x_reg, x_next, y_reg, y_next;
   logic [10:0] r_reg, r_next;
   logic        res_we_reg, res_we_next, res_data_reg, res_data_next;
   logic [7:0]  res_addr_reg, res_addr_next;
   logic        pf_start, pf_abort, load_en, more_obj;
   logic [10:0] pf_base;
   logic [30:0] load_word;
   logic [30:0] buf_mem [0:5];

   assign more_obj = (9'(obj_idx_reg) + 9'd1) < 9'(num_reg);

   // One write port per buffer slot, selected by the capture counter.
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_buf
         always_ff @(posedge clk) begin
            if (rd_d_reg && cap_cnt_reg == 3'(gi))
               buf_mem[gi] <= rom_data;
         end
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      err_next      = err_reg;
      rom_rd_next   = rom_rd_reg;
      rom_addr_next = rom_addr_reg;
      next_addr_next = next_addr_reg;
      rd_cnt_next   = rd_cnt_reg;
      cap_cnt_next  = cap_cnt_reg;
      pf_done_next  = pf_done_reg;
      send_cnt_next = send_cnt_reg;
      wait_cnt_next = wait_cnt_reg;
      obj_idx_next  = obj_idx_reg;
      num_next      = num_reg;
      gf_reset_next = gf_reset_reg;
      x_next        = x_reg;
      y_next        = y_reg;
      r_next        = r_reg;
      res_we_next   = 1'b0;
      res_addr_next = res_addr_reg;
      res_data_next = res_data_reg;
      pf_start      = 1'b0;
      pf_abort      = 1'b0;
      pf_base       = next_addr_reg;
      load_en       = 1'b0;
      load_word     = buf_mem[0];

      // Prefetch engine: six reads at a running address, capture one cycle later.
      if (rom_rd_reg) begin
         if (rd_cnt_reg < 3'd6) begin
            rom_addr_next  = next_addr_reg;
            next_addr_next = next_addr_reg + 11'd1;
            rd_cnt_next    = rd_cnt_reg + 3'd1;
         end else begin
            rom_rd_next = 1'b0;
         end
      end
      if (rd_d_reg) begin
         cap_cnt_next = cap_cnt_reg + 3'd1;
         if (cap_cnt_reg == 3'd5)
            pf_done_next = 1'b1;
      end

      case (state_reg)
         IDLE: begin
            gf_reset_next = 1'b1;
            if (start) begin
               err_next     = 1'b0;
               busy_next    = 1'b1;
               obj_idx_next = 8'd0;
               num_next     = num_obj;
               if (num_obj == 8'd0) begin
                  state_next = FIN;
                  done_next  = 1'b1;
               end else begin
                  state_next = PREF;
                  pf_start   = 1'b1;
                  pf_base    = 11'd0;
               end
            end
         end
         PREF: begin
            if (rd_d_reg && cap_cnt_reg == 3'd5) begin
               load_en       = 1'b1;
               gf_reset_next = 1'b0;
               send_cnt_next = 3'd0;
               state_next    = SEND;
            end
         end
         SEND: begin
            if (send_cnt_reg < 3'd5) begin
               load_en       = 1'b1;
               load_word     = buf_mem[send_cnt_reg + 3'd1];
               send_cnt_next = send_cnt_reg + 3'd1;
            end else begin
               wait_cnt_next = 10'd0;
               state_next    = WAIT;
               pf_start      = more_obj;
            end
         end
         WAIT: begin
            if (valid) begin
               if (more_obj && !pf_done_reg) begin
                  err_next      = 1'b1;
                  gf_reset_next = 1'b1;
                  pf_abort      = 1'b1;
                  done_next     = 1'b1;
                  state_next    = FIN;
               end else begin
                  res_we_next   = 1'b1;
                  res_addr_next = obj_idx_reg;
                  res_data_next = is_inside;
                  if (more_obj) begin
                     load_en       = 1'b1;
                     obj_idx_next  = obj_idx_reg + 8'd1;
                     send_cnt_next = 3'd0;
                     state_next    = SEND;
                  end else begin
                     gf_reset_next = 1'b1;
                     done_next     = 1'b1;
                     state_next    = FIN;
                  end
               end
            end else if (wait_cnt_reg == WAIT_LAST) begin
               err_next      = 1'b1;
               gf_reset_next = 1'b1;
               pf_abort      = 1'b1;
               done_next     = 1'b1;
               state_next    = FIN;
            end else begin
               wait_cnt_next = wait_cnt_reg + 10'd1;
            end
         end
         FIN: begin
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (load_en) begin
         x_next = load_word[30:21];
         y_next = load_word[20:11];
         r_next = load_word[10:0];
      end
      if (pf_start) begin
         rom_rd_next    = 1'b1;
         rom_addr_next  = pf_base;
         next_addr_next = pf_base + 11'd1;
         rd_cnt_next    = 3'd1;
         cap_cnt_next   = 3'd0;
         pf_done_next   = 1'b0;
      end
      if (pf_abort)
         rom_rd_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         rom_rd_reg    <= 1'b0;
         rd_d_reg      <= 1'b0;
         pf_done_reg   <= 1'b0;
         rom_addr_reg  <= 11'd0;
         next_addr_reg <= 11'd0;
         rd_cnt_reg    <= 3'd0;
         cap_cnt_reg   <= 3'd0;
         send_cnt_reg  <= 3'd0;
         wait_cnt_reg  <= 10'd0;
         obj_idx_reg   <= 8'd0;
         num_reg       <= 8'd0;
         gf_reset_reg  <= 1'b1;
         x_reg         <= 10'd0;
         y_reg         <= 10'd0;
         r_reg         <= 11'd0;
         res_we_reg    <= 1'b0;
         res_addr_reg  <= 8'd0;
         res_data_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
         rom_rd_reg    <= rom_rd_next;
         rd_d_reg      <= rom_rd_reg;
         pf_done_reg   <= pf_done_next;
         rom_addr_reg  <= rom_addr_next;
         next_addr_reg <= next_addr_next;
         rd_cnt_reg    <= rd_cnt_next;
         cap_cnt_reg   <= cap_cnt_next;
         send_cnt_reg  <= send_cnt_next;
         wait_cnt_reg  <= wait_cnt_next;
         obj_idx_reg   <= obj_idx_next;
         num_reg       <= num_next;
         gf_reset_reg  <= gf_reset_next;
         x_reg         <= x_next;
         y_reg         <= y_next;
         r_reg         <= r_next;
         res_we_reg    <= res_we_next;
         res_addr_reg  <= res_addr_next;
         res_data_reg  <= res_data_next;
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign err      = err_reg;
   assign rom_rd   = rom_rd_reg;
   assign rom_addr = rom_addr_reg;
   assign gf_reset = gf_reset_reg;
   assign X        = x_reg;
   assign Y        = y_reg;
   assign R        = r_reg;
   assign res_we   = res_we_reg;
   assign res_addr = res_addr_reg;
   assign res_data = res_data_reg;

endmodule

// File: doc/geofence_host.md
GEOFENCE_HOST -- requirements
Module: geofence_host

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, maximum WAIT cycles allowed before valid; range 64..1023.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse; begins a run (ignored while busy=1).
REQ-005 num_obj  in  8  objects in run, sampled on start.
REQ-006 busy  out  1  high from start acceptance through done.
REQ-007 done  out  1  one-cycle pulse at run end.
REQ-008 err  out  1  sticky run error, cleared on next accepted start.
REQ-009 rom_rd  out  1  pattern ROM read strobe.
REQ-010 rom_addr  out  11  ROM word address; object i point k = 6*i+k.
REQ-011 rom_data  in  31  {X[30:21],Y[20:11],R[10:0]}, valid one cycle after rom_rd.
REQ-012 gf_reset  out  1  reset driven to geofence receiver.
REQ-013 X  out  10, Y  out  10, R  out  11: point presented to receiver.
REQ-014 valid  in  1, is_inside  in  1: receiver result, one-cycle pulse.
REQ-015 res_we  out  1, res_addr  out  8, res_data  out  1: result write port.

Function
REQ-016 The receiver samples X/Y/R on 6 consecutive cycles immediately after gf_reset release or after the cycle it asserts valid; the block SHALL match this exactly.
REQ-017 FSM states SHALL be IDLE, PREF, SEND, WAIT, FIN.
REQ-018 IDLE: gf_reset=1; on start with num_obj=0 -> FIN without ROM reads; with num_obj>0 -> PREF, busy=1, rom address counter=0.
REQ-019 PREF: gf_reset=1; rom_rd high 6 cycles at consecutive addresses; each returned word written to 6-entry buffer buf[0..5].
REQ-020 At the edge capturing buf[5] in PREF: gf_reset<=0, X/Y/R<=buf[0], state<=SEND.
REQ-021 SEND: all outputs registered; each edge loads buf[1]..buf[5] in order; at the edge ending the cycle that presents point 5 -> WAIT; point 0 through point 5 thus each present exactly one cycle.
REQ-022 WAIT: X/Y/R hold point 5; if objects remain, prefetch next object's 6 words into buf from first WAIT cycle (buffer free after SEND); wait counter increments each cycle.
REQ-023 valid sampled in WAIT with prefetch complete or none needed: res_we<=1, res_addr<=object index, res_data<=is_inside (res_we a single-cycle pulse).
REQ-024 Same edge, objects remain: X/Y/R<=buf[0], object index+1, state<=SEND (next object's point 0 presented in cycle immediately after valid).
REQ-025 Same edge, last object: gf_reset<=1, state<=FIN.
REQ-026 FIN: done=1 one cycle, busy<=0, -> IDLE.
REQ-027 valid in WAIT before prefetch complete: err<=1, gf_reset<=1, no result write, -> FIN.
REQ-028 Wait counter reaching TIMEOUT_CYC without valid: err<=1, gf_reset<=1, -> FIN.
REQ-029 valid outside WAIT SHALL be ignored; start while busy SHALL be ignored.
REQ-030 ROM address SHALL be a running counter (no multiplier); max 1529.

Reset
REQ-031 On reset: state IDLE, gf_reset=1, busy=0, done=0, err=0, rom_rd=0, rom_addr=0, X=Y=R=0, res_we=0, res_addr=0, res_data=0, buffer contents don't-care.
REQ-032 Reset mid-run SHALL abandon the run with no further ROM reads or result writes; next start behaves as from power-up.

Verification
REQ-033 num_obj=1, ROM[0..5]=(10,10,5),(20,10,5),...: rom_addr 0..5, gf_reset falls, X=10,20,... on 6 consecutive cycles; valid with is_inside=1 -> res_we, res_addr=0, res_data=1; done next cycle; gf_reset=1.
REQ-034 num_obj=3 with receiver model: rom_addr 6..11 and 12..17 read during WAIT; point 0 of objects 1 and 2 present in cycle after each valid; res_addr 0,1,2 written in order.
REQ-035 num_obj=0: done pulses one cycle after start; rom_rd never asserted; err=0.
REQ-036 valid withheld, TIMEOUT_CYC=64: err=1 after 64 WAIT cycles; done pulse; gf_reset=1; no res_we.
REQ-037 num_obj=2, valid forced 3 cycles into WAIT: err=1, no res_we for object 0, done pulse.
REQ-038 reset asserted on 3rd SEND cycle: next cycle all outputs at REQ-031 values; new start with num_obj=1 completes normally.
